dmem_mmio: RTL and testbench

Data-memory stage sitting directly downstream of the single-cycle MIPS core's data port. It consumes the core's data address, store data and write strobe, and returns load data combinationally. It maps a word-addressed RAM plus a small MMIO window holding an output (TX) FIFO drained by a valid/ready handshake, a status register, and an optional free-running cycle counter. The core has no stall input, so every access completes in one cycle; FIFO overflow is flagged, never stalled.

---
 rtl/dmem_mmio_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/dmem_mmio.sv | 133 +++++++++++++
 tb/tb_dmem_mmio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio shared definitions: MMIO map, STATUS layout, decode select.
// Used by dmem_mmio and its FIFO; optional CYCLES counter via DMEM_CYCLE_CNT_EN.
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CYCLES = 16'h0008;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STATUS,
    SEL_CYC,
    SEL_NONE
  } mmio_sel_e;

  function automatic logic [31:0] status_word(
    input logic       empty,
    input logic       full,
    input logic       ovf,
    input logic [7:0] cnt
  );
    logic [31:0] w;
    w                      = '0;
    w[ST_EMPTY]            = empty;
    w[ST_FULL]             = full;
    w[ST_OVF]              = ovf;
    w[ST_COUNT_LSB +: 8]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; a push while full is taken only
// when the same cycle also pops, so a full FIFO can stream.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // storage write; contents need no reset since count gates the head
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with MMIO window: RAM, TX FIFO, STATUS, optional CYCLES.
// Define DMEM_CYCLE_CNT_EN to build the free-running CYCLES counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH);

  logic [31:0] ram [DEPTH_WORDS];
  logic [IW-1:0] ram_idx;

  logic        is_mmio;
  logic [15:0] off;
  mmio_sel_e   sel;
  logic        unused_addr_bits;

  logic          push_req;
  logic          pop;
  logic [31:0]   fifo_head;
  logic [CW:0]   fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;

  logic        ovf;
  logic        ovf_set;
  logic        ovf_clr;
  logic [31:0] cyc_val;
  logic [31:0] status;

  assign is_mmio          = (addr[31:16] == MMIO_BASE);
  assign off              = {addr[15:2], 2'b00};
  assign ram_idx          = addr[IW+1:2];
  assign unused_addr_bits = ^addr[1:0];

  // address decode into one access target
  always_comb begin
    sel = SEL_RAM;
    if (is_mmio) begin
      unique case (1'b1)
        (off == OFF_TXDATA): sel = SEL_TX;
        (off == OFF_STATUS): sel = SEL_STATUS;
        (off == OFF_CYCLES): sel = SEL_CYC;
        default:             sel = SEL_NONE;
      endcase
    end
  end

  assign push_req = we && (sel == SEL_TX);
  assign pop      = tx_valid && tx_ready;
  assign ovf_set  = push_req && fifo_full && !pop;
  assign ovf_clr  = we && (sel == SEL_STATUS) && wdata[ST_OVF];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (wdata),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  // word store into RAM; upper address bits alias
  always_ff @(posedge clk) begin
    if (we && (sel == SEL_RAM)) begin
      ram[ram_idx] <= wdata;
    end
  end

  // sticky overflow: set on a dropped push, cleared by STATUS write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycles;

  // free-running cycle count, wraps at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  assign cyc_val = cycles;
`else
  assign cyc_val = '0;
`endif

  assign status = status_word(fifo_empty, fifo_full, ovf, 8'(fifo_cnt));

  // load data mux, combinational from pre-edge state
  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_RAM:    rdata = ram[ram_idx];
      SEL_STATUS: rdata = status;
      SEL_CYC:    rdata = cyc_val;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized scoreboard bench for dmem_mmio against a queue-based model.
// Optional CYCLES expectations follow DMEM_CYCLE_CNT_EN.
module tb_dmem_mmio;

  localparam int DW = 256;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  dmem_mmio #(
    .DEPTH_WORDS (DW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram_m [int];
  logic [31:0] fq[$];
  logic [31:0] txq[$];
  logic [31:0] rexp_q[$];
  string       rname_q[$];
  bit          ovf_m;
  int unsigned cyc_m;
  bit          exp_valid;
  bit          rd_chk;

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a,
                                             output bit ok);
    int sz;
    int idx;
    ok = 1'b1;
    sz = fq.size();
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0] & 16'hFFFC)
        16'h0004: return (sz << 8) | (int'(ovf_m) << 2) |
                         (int'(sz == FD) << 1) | int'(sz == 0);
`ifdef DMEM_CYCLE_CNT_EN
        16'h0008: return cyc_m;
`endif
        default:  return 32'h0;
      endcase
    end
    idx = int'((a >> 2) % DW);
    ok  = ram_m.exists(idx);
    return ok ? ram_m[idx] : 32'h0;
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic rdy, input bit chk,
                      input string nm);
    bit          ok;
    logic [31:0] e;
    int          pre;
    bit          pp;
    bit          mmio;
    addr     = a;
    wdata    = d;
    we       = w;
    tx_ready = rdy;
    pre       = fq.size();
    exp_valid = (pre > 0);
    e = model_read(a, ok);
    rd_chk = chk && ok;
    if (rd_chk) begin
      rexp_q.push_back(e);
      rname_q.push_back(nm);
    end
    mmio = (a[31:16] == 16'hFFFF);
    pp   = (pre > 0) && rdy;
    if (pp) txq.push_back(fq.pop_front());
    if (w && mmio && (a[15:0] & 16'hFFFC) == 16'h0000) begin
      if (pre < FD || pp) fq.push_back(d);
      else ovf_m = 1'b1;
    end
    if (w && mmio && (a[15:0] & 16'hFFFC) == 16'h0004 && d[2])
      ovf_m = 1'b0;
    if (w && !mmio) ram_m[int'((a >> 2) % DW)] = d;
    cyc_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, rdy, 1'b0, "idle");
  endtask

  task automatic do_reset();
    we       = 1'b0;
    tx_ready = 1'b0;
    rd_chk   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", tx_data, 32'h0);
    fq.delete();
    txq.delete();
    ovf_m     = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_m = 0;
  endtask

  // scoreboard monitor: compares DUT outputs against queued expectations
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("tx_valid", 32'(tx_valid), 32'(exp_valid));
      if (exp_valid && tx_ready) begin
        if (txq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_pop: got %08h expected none", tx_data);
        end else begin
          check("tx_data", tx_data, txq.pop_front());
        end
      end
      if (rd_chk) check(rname_q.pop_front(), rdata, rexp_q.pop_front());
    end
  end

  localparam logic [31:0] TXD = 32'hFFFF_0000;
  localparam logic [31:0] STS = 32'hFFFF_0004;
  localparam logic [31:0] CYC = 32'hFFFF_0008;

  initial begin
    logic [31:0] a;
    int          r;
    addr     = '0;
    wdata    = '0;
    we       = 1'b0;
    tx_ready = 1'b0;
    rd_chk   = 1'b0;
    rst_n    = 1'b0;
    cyc_m    = 0;
    ovf_m    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    step(STS, 0, 0, 0, 1, "status_reset");

    step(32'h10, 32'hDEADBEEF, 1, 0, 0, "ram_wr");
    step(32'h10, 0, 0, 0, 1, "ram_rd");
    step(32'h410, 0, 0, 0, 1, "ram_alias");
    step(32'h10, 32'h12345678, 1, 0, 1, "ram_same_cycle_old");
    step(32'h10, 0, 0, 0, 1, "ram_rd_new");

    for (int i = 1; i <= 3; i++) step(TXD, i, 1, 0, 1, "txdata_rd");
    step(STS, 0, 0, 0, 1, "status_3");
    idle(1'b1, 4);
    step(STS, 0, 0, 0, 1, "status_drained");

    for (int i = 1; i <= 9; i++) step(TXD, i, 1, 0, 0, "push");
    step(STS, 0, 0, 0, 1, "status_ovf");
    idle(1'b1, 8);
    step(STS, 32'h4, 1, 0, 1, "status_pre_clr");
    step(STS, 0, 0, 0, 1, "status_clr");

    for (int i = 0; i < 8; i++) step(TXD, 32'h11 + i, 1, 0, 0, "push");
    step(TXD, 32'hAA, 1, 1, 0, "push_pop_full");
    step(STS, 0, 0, 0, 1, "status_full_pp");
    idle(1'b1, 9);

    for (int i = 0; i < 5; i++) step(TXD, 32'h50 + i, 1, 0, 0, "push");
    step(32'h0, 0, 0, 1, 0, "drain1");
    do_reset();
    step(STS, 0, 0, 0, 1, "status_after_rst");

    step(CYC, 0, 0, 0, 1, "cycles_a");
    idle(1'b0, 9);
    step(CYC, 32'hFFFF_FFFF, 1, 0, 1, "cycles_b");
    step(CYC, 0, 0, 0, 1, "cycles_c");

    for (int i = 0; i < 16; i++)
      step(i << 2, $urandom, 1, 0, 0, "ram_init");

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = {16'($urandom_range(0, 16'hFFFE)), 6'($urandom),
             8'($urandom_range(0, 15)), 2'($urandom)};
        step(a, $urandom, r < 2, 1'($urandom), 1, "rnd_ram");
      end else begin
        a = TXD | 32'($urandom_range(0, 4) * 4) | 32'($urandom_range(0, 3));
        step(a, $urandom, r < 8, 1'($urandom), 1, "rnd_mmio");
      end
    end

    idle(1'b1, FD + 1);
    check("txq_empty", 32'(txq.size()), 32'h0);
    check("rexp_empty", 32'(rexp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
